ctrl_decode_pipe: RTL and testbench

//  Registered successor to the combinational control decoder. Decodes the opcode of the

---
 rtl/ctrl_decode_pipe_pkg.sv | 63 ++++++
 rtl/ctrl_decode_pipe_if.sv | 28 ++
 rtl/ctrl_decode_pipe_comb.sv | 89 ++++++++
 rtl/ctrl_decode_pipe.sv | 106 ++++++++++
 tb/tb_ctrl_decode_pipe.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared definitions for the registered control decoder: opcodes, control-bundle
// layout, select-field encodings and sequencer states.
package ctrl_decode_pipe_pkg;

  // Bundle = {reserved zeros, flags, alu_op[OPC_W-1:0]}; reserved bits always read 0.
  localparam int CTRL_W  = 24;
  localparam int FLAGS_W = 15;

  localparam logic [4:0] OPC_HALT    = 5'b00000;
  localparam logic [4:0] OPC_NOP     = 5'b00001;
  localparam logic [4:0] OPC_SIIC    = 5'b00010;
  localparam logic [4:0] OPC_RTI     = 5'b00011;
  localparam logic [4:0] OPC_ST      = 5'b10000;
  localparam logic [4:0] OPC_LD      = 5'b10001;
  localparam logic [4:0] OPC_SLBI    = 5'b10010;
  localparam logic [4:0] OPC_STU     = 5'b10011;
  localparam logic [4:0] OPC_LBI     = 5'b11000;
  localparam logic [4:0] OPC_MEM_ALU = 5'b01000;

  localparam logic [CTRL_W-1:0] CTRL_NOP = 24'h000001;

  typedef enum logic [1:0] {
    DEST_RD_I = 2'b00,
    DEST_RD_R = 2'b01,
    DEST_RS   = 2'b10,
    DEST_R7   = 2'b11
  } dest_sel_e;

  typedef enum logic [2:0] {
    IMM_I5_ZX  = 3'b000,
    IMM_I8_ZX  = 3'b001,
    IMM_I5_SX  = 3'b100,
    IMM_I8_SX  = 3'b101,
    IMM_D11_SX = 3'b110
  } imm_sel_e;

  typedef enum logic [1:0] {
    LINK_ALU = 2'b00,
    LINK_IMM = 2'b01,
    LINK_PC2 = 2'b10
  } link_sel_e;

  typedef struct packed {
    logic      reg_write;
    dest_sel_e dest_sel;
    logic      pc_rel;
    logic      reg_jmp;
    logic      mem_en;
    logic      mem_wr;
    logic      val2reg;
    logic      alu_imm;
    imm_sel_e  imm_sel;
    link_sel_e link_sel;
    logic      is_branch;
  } ctrl_flags_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_SQUASH = 2'b01,
    ST_HALTED = 2'b10
  } fsm_state_e;

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// ID-side request and EX-side control/redirect signals of the control decoder.
interface ctrl_decode_pipe_if #(
    parameter int OPC_W = 5,
    parameter int PC_W  = 16
);
    logic                                      id_valid_i;
    logic [OPC_W-1:0]                          id_opc_i;
    logic [PC_W-1:0]                           id_pc2_i;
    logic                                      stall_i;
    logic                                      flush_i;
    logic                                      ex_valid_o;
    logic [ctrl_decode_pipe_pkg::CTRL_W-1:0]   ex_ctrl_o;
    logic                                      redirect_o;
    logic [PC_W-1:0]                           redirect_pc_o;
    logic [PC_W-1:0]                           epc_o;
    logic                                      halt_o;
    logic                                      err_o;

    modport master (
        output id_valid_i, id_opc_i, id_pc2_i, stall_i, flush_i,
        input  ex_valid_o, ex_ctrl_o, redirect_o, redirect_pc_o, epc_o, halt_o, err_o
    );

    modport slave (
        input  id_valid_i, id_opc_i, id_pc2_i, stall_i, flush_i,
        output ex_valid_o, ex_ctrl_o, redirect_o, redirect_pc_o, epc_o, halt_o, err_o
    );
endinterface

// File: rtl/ctrl_decode_pipe_comb.sv
// Pure opcode decoder: opcode -> packed control bundle plus sequencer classification.
module ctrl_decode_comb
    import ctrl_decode_pipe_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0]  opc,
    output logic [CTRL_W-1:0] ctrl,
    output logic              is_halt,
    output logic              is_trap,
    output logic              is_rti,
    output logic              illegal
);
    logic [4:0]       op;
    logic [OPC_W-1:0] aop;
    ctrl_flags_t      f;

    always_comb begin
        op      = opc[4:0];
        aop     = opc;
        f       = '0;
        // Any set bit above the 5-bit opcode field makes the instruction illegal.
        illegal = |(opc >> 5);

        unique casez (op)
            5'b000??: begin
            end
            5'b001??: begin
                f.dest_sel = DEST_R7;
                f.imm_sel  = op[0] ? IMM_I8_SX : IMM_D11_SX;
                f.reg_jmp  = op[0];
                f.pc_rel   = ~op[0];
                if (op[1]) begin
                    f.link_sel  = LINK_PC2;
                    f.reg_write = 1'b1;
                end
            end
            5'b010??, 5'b101??: begin
                f.reg_write = 1'b1;
                f.dest_sel  = DEST_RD_I;
                f.alu_imm   = 1'b1;
                f.imm_sel   = op[1] ? IMM_I5_ZX : IMM_I5_SX;
            end
            5'b011??: begin
                f.is_branch = 1'b1;
                f.imm_sel   = IMM_I8_SX;
            end
            OPC_ST, OPC_LD: begin
                f.mem_en    = 1'b1;
                f.mem_wr    = ~op[0];
                f.val2reg   = op[0];
                f.reg_write = op[0];
                aop         = OPC_W'(OPC_MEM_ALU);
            end
            OPC_STU: begin
                f.mem_en    = 1'b1;
                f.mem_wr    = 1'b1;
                f.reg_write = 1'b1;
                f.dest_sel  = DEST_RS;
                f.imm_sel   = IMM_I5_SX;
                aop         = OPC_W'(OPC_MEM_ALU);
            end
            OPC_LBI: begin
                f.reg_write = 1'b1;
                f.dest_sel  = DEST_RS;
                f.imm_sel   = IMM_I8_SX;
                f.link_sel  = LINK_IMM;
            end
            OPC_SLBI: begin
                f.reg_write = 1'b1;
                f.dest_sel  = DEST_RS;
                f.imm_sel   = IMM_I8_ZX;
            end
            default: begin
                f.reg_write = 1'b1;
                f.dest_sel  = DEST_RD_R;
            end
        endcase

        ctrl                   = '0;
        ctrl[OPC_W-1:0]        = aop;
        ctrl[OPC_W +: FLAGS_W] = f;
        if (illegal) ctrl = CTRL_NOP;

        is_halt = ~illegal & (op == OPC_HALT);
        is_trap = ~illegal & (op == OPC_SIIC);
        is_rti  = ~illegal & (op == OPC_RTI);
    end
endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID/EX control register with stall/flush handling and a HALT / trap / RTI sequencer
// that saves EPC and issues a one-cycle registered PC redirect.
module ctrl_decode_pipe
    import ctrl_decode_pipe_pkg::*;
#(
    parameter int              OPC_W   = 5,
    parameter int              PC_W    = 16,
    parameter logic [PC_W-1:0] EXC_VEC = 16'h0002
) (
    input logic              clk,
    input logic              rst,
    ctrl_decode_pipe_if.slave bus
);
    fsm_state_e        state;
    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic              redir_p1;
    logic [PC_W-1:0]   redir_pc_p1;
    logic [PC_W-1:0]   epc;
    logic              halt_flag;
    logic              err_flag;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_halt;
    logic              dec_trap;
    logic              dec_rti;
    logic              dec_illegal;
    logic              accept;

    ctrl_decode_comb #(.OPC_W(OPC_W)) u_dec (
        .opc     (bus.id_opc_i),
        .ctrl    (dec_ctrl),
        .is_halt (dec_halt),
        .is_trap (dec_trap),
        .is_rti  (dec_rti),
        .illegal (dec_illegal)
    );

    assign accept = bus.id_valid_i & ~bus.stall_i & ~bus.flush_i & (state == ST_RUN);

    // ID -> EX boundary: control register, sequencer, EPC and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            vld_p1      <= 1'b0;
            ctrl_p1     <= CTRL_NOP;
            redir_p1    <= 1'b0;
            redir_pc_p1 <= '0;
            epc         <= '0;
            halt_flag   <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            redir_p1 <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    if (bus.flush_i) begin
                        vld_p1  <= 1'b0;
                        ctrl_p1 <= CTRL_NOP;
                    end else if (accept) begin
                        if (dec_halt) begin
                            vld_p1    <= 1'b1;
                            ctrl_p1   <= dec_ctrl;
                            halt_flag <= 1'b1;
                            state     <= ST_HALTED;
                        end else if (dec_trap | dec_illegal) begin
                            epc         <= bus.id_pc2_i;
                            redir_p1    <= 1'b1;
                            redir_pc_p1 <= EXC_VEC;
                            vld_p1      <= 1'b0;
                            ctrl_p1     <= CTRL_NOP;
                            err_flag    <= err_flag | dec_illegal;
                            state       <= ST_SQUASH;
                        end else if (dec_rti) begin
                            redir_p1    <= 1'b1;
                            redir_pc_p1 <= epc;
                            vld_p1      <= 1'b0;
                            ctrl_p1     <= CTRL_NOP;
                            state       <= ST_SQUASH;
                        end else begin
                            vld_p1  <= 1'b1;
                            ctrl_p1 <= dec_ctrl;
                        end
                    end else if (!bus.stall_i) begin
                        vld_p1 <= 1'b0;
                    end
                end
                // The instruction sitting in ID during the redirect is wrong-path.
                ST_SQUASH: begin
                    vld_p1 <= 1'b0;
                    state  <= ST_RUN;
                end
                default: begin
                    vld_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ex_valid_o    = vld_p1;
    assign bus.ex_ctrl_o     = ctrl_p1;
    assign bus.redirect_o    = redir_p1;
    assign bus.redirect_pc_o = redir_pc_p1;
    assign bus.epc_o         = epc;
    assign bus.halt_o        = halt_flag;
    assign bus.err_o         = err_flag;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: directed scenarios plus randomized traffic
// compared against a behavioural model of the decoder and sequencer.
module tb_ctrl_decode_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_decode_pipe_if #(.OPC_W(5), .PC_W(16)) bus5 ();
    ctrl_decode_pipe_if #(.OPC_W(6), .PC_W(16)) bus6 ();

    ctrl_decode_pipe #(.OPC_W(5), .PC_W(16), .EXC_VEC(16'h0002)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5));
    ctrl_decode_pipe #(.OPC_W(6), .PC_W(16), .EXC_VEC(16'h0002)) dut6 (
        .clk(clk), .rst(rst), .bus(bus6));

    int checks   = 0;
    int failures = 0;

    // model state for the OPC_W=5 instance: 0 run, 1 squash, 2 halted
    int          m_state;
    logic        m_vld, m_ctrl_chk, m_redir, m_halt, m_err;
    logic [23:0] m_ctrl;
    logic [15:0] m_rpc, m_epc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected bundle written from the opcode map: {4'b0, flags, alu_op}.
    function automatic logic [23:0] ref_bundle(input logic [4:0] o);
        logic rw, pcr, rj, me, mw, v2r, ai, br;
        logic [1:0] dst, lnk;
        logic [2:0] isel;
        logic [4:0] aop;
        int n;
        n = int'(o);
        {rw, pcr, rj, me, mw, v2r, ai, br} = 8'h00;
        dst = 2'd0; lnk = 2'd0; isel = 3'd0; aop = o;
        if (n >= 4 && n <= 7) begin
            dst = 2'b11; rj = (n % 2 == 1); pcr = (n % 2 == 0);
            isel = (n % 2 == 1) ? 3'b101 : 3'b110;
            if (n >= 6) begin lnk = 2'b10; rw = 1'b1; end
        end else if ((n >= 8 && n <= 11) || (n >= 20 && n <= 23)) begin
            rw = 1'b1; ai = 1'b1;
            isel = (n == 10 || n == 11 || n == 22 || n == 23) ? 3'b000 : 3'b100;
        end else if (n >= 12 && n <= 15) begin
            br = 1'b1; isel = 3'b101;
        end else if (n == 16) begin
            me = 1'b1; mw = 1'b1; aop = 5'd8;
        end else if (n == 17) begin
            me = 1'b1; v2r = 1'b1; rw = 1'b1; aop = 5'd8;
        end else if (n == 18) begin
            rw = 1'b1; dst = 2'b10; isel = 3'b001;
        end else if (n == 19) begin
            me = 1'b1; mw = 1'b1; rw = 1'b1; dst = 2'b10; isel = 3'b100; aop = 5'd8;
        end else if (n == 24) begin
            rw = 1'b1; dst = 2'b10; isel = 3'b101; lnk = 2'b01;
        end else if (n >= 25) begin
            rw = 1'b1; dst = 2'b01;
        end
        return {4'b0000, rw, dst, pcr, rj, me, mw, v2r, ai, isel, lnk, br, aop};
    endfunction

    task automatic model_reset();
        m_state = 0; m_vld = 0; m_ctrl = 24'h000001; m_ctrl_chk = 1;
        m_redir = 0; m_rpc = 16'h0; m_epc = 16'h0; m_halt = 0; m_err = 0;
    endtask

    task automatic model_step();
        logic v, st, fl;
        logic [4:0] o;
        logic [15:0] pc;
        v = bus5.id_valid_i; o = bus5.id_opc_i; pc = bus5.id_pc2_i;
        st = bus5.stall_i; fl = bus5.flush_i;
        m_redir = 0;
        if (m_state == 1) begin
            m_vld = 0; m_ctrl_chk = 0; m_state = 0;
        end else if (m_state == 2) begin
            m_vld = 0; m_ctrl_chk = 0;
        end else if (fl) begin
            m_vld = 0; m_ctrl = 24'h000001; m_ctrl_chk = 1;
        end else if (st) begin
            m_vld = m_vld;
        end else if (!v) begin
            m_vld = 0; m_ctrl_chk = 0;
        end else if (o == 5'd0) begin
            m_vld = 1; m_ctrl = ref_bundle(o); m_ctrl_chk = 1; m_halt = 1; m_state = 2;
        end else if (o == 5'd2 || o == 5'd3) begin
            m_redir = 1;
            m_rpc = (o == 5'd2) ? 16'h0002 : m_epc;
            if (o == 5'd2) m_epc = pc;
            m_vld = 0; m_ctrl = 24'h000001; m_ctrl_chk = 1; m_state = 1;
        end else begin
            m_vld = 1; m_ctrl = ref_bundle(o); m_ctrl_chk = 1;
        end
    endtask

    task automatic compare_all();
        check_val("ex_valid", bus5.ex_valid_o, m_vld);
        if (m_ctrl_chk) check_val("ex_ctrl", bus5.ex_ctrl_o, m_ctrl);
        check_val("redirect", bus5.redirect_o, m_redir);
        if (m_redir) check_val("redirect_pc", bus5.redirect_pc_o, m_rpc);
        check_val("epc", bus5.epc_o, m_epc);
        check_val("halt", bus5.halt_o, m_halt);
        check_val("err", bus5.err_o, m_err);
    endtask

    task automatic check_reset6();
        check_val("r6_valid", bus6.ex_valid_o, 0);
        check_val("r6_ctrl", bus6.ex_ctrl_o, 24'h000001);
        check_val("r6_redir", bus6.redirect_o, 0);
        check_val("r6_epc", bus6.epc_o, 0);
        check_val("r6_halt", bus6.halt_o, 0);
        check_val("r6_err", bus6.err_o, 0);
    endtask

    task automatic drive5(input logic v, input logic [4:0] o, input logic [15:0] pc,
                          input logic st, input logic fl);
        bus5.id_valid_i = v; bus5.id_opc_i = o; bus5.id_pc2_i = pc;
        bus5.stall_i = st; bus5.flush_i = fl;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #3 rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        check_reset6();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0] c;
        int halt_cnt;
        rst = 1'b1;
        drive5(0, 5'd0, 16'h0, 0, 0);
        bus6.id_valid_i = 0; bus6.id_opc_i = '0; bus6.id_pc2_i = '0;
        bus6.stall_i = 0; bus6.flush_i = 0;
        model_reset();
        #1;
        compare_all();
        check_reset6();
        @(negedge clk);
        rst = 1'b0;

        // T1: ADD
        drive5(1, 5'b11011, 16'h0010, 0, 0); tick();
        c = bus5.ex_ctrl_o;
        check_val("t1_valid", bus5.ex_valid_o, 1);
        check_val("t1_reg_write", c[19], 1);
        check_val("t1_dest_sel", c[18:17], 2'b01);
        check_val("t1_alu_imm", c[11], 0);

        // T2: LD held by a three-cycle stall
        drive5(1, 5'b10001, 16'h0012, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive5(1, 5'b11011, 16'h0014, 1, 0); tick();
            c = bus5.ex_ctrl_o;
            check_val("t2_valid", bus5.ex_valid_o, 1);
            check_val("t2_mem_en", c[14], 1);
            check_val("t2_val2reg", c[12], 1);
            check_val("t2_mem_wr", c[13], 0);
            check_val("t2_alu_op", c[4:0], 5'b01000);
        end

        // T3: SIIC, wrong-path drop (stall does not extend squash), RTI, nested SIIC
        drive5(1, 5'b00010, 16'h0040, 0, 0); tick();
        check_val("t3_redir", bus5.redirect_o, 1);
        check_val("t3_rpc", bus5.redirect_pc_o, 16'h0002);
        check_val("t3_epc", bus5.epc_o, 16'h0040);
        check_val("t3_valid", bus5.ex_valid_o, 0);
        drive5(1, 5'b11011, 16'h0042, 1, 0); tick();
        check_val("t3_drop", bus5.ex_valid_o, 0);
        check_val("t3_pulse", bus5.redirect_o, 0);
        drive5(1, 5'b11011, 16'h0044, 0, 0); tick();
        check_val("t3_resume", bus5.ex_valid_o, 1);
        drive5(1, 5'b00011, 16'h0046, 0, 0); tick();
        check_val("t3_rti_redir", bus5.redirect_o, 1);
        check_val("t3_rti_pc", bus5.redirect_pc_o, 16'h0040);
        drive5(0, 5'd0, 16'h0, 0, 0); tick();
        drive5(1, 5'b00010, 16'h0080, 0, 0); tick();
        drive5(0, 5'd0, 16'h0, 0, 0); tick();
        drive5(1, 5'b00010, 16'h00a0, 0, 0); tick();
        check_val("t3_nested_epc", bus5.epc_o, 16'h00a0);
        drive5(0, 5'd0, 16'h0, 0, 0); tick();
        drive5(1, 5'b00011, 16'h00b0, 0, 0); tick();
        check_val("t3_nested_rti", bus5.redirect_pc_o, 16'h00a0);
        drive5(0, 5'd0, 16'h0, 0, 0); tick();

        // T4: flush and stall together on JAL
        drive5(1, 5'b11011, 16'h0100, 0, 0); tick();
        drive5(1, 5'b00110, 16'h0102, 1, 1); tick();
        check_val("t4_valid", bus5.ex_valid_o, 0);
        check_val("t4_ctrl", bus5.ex_ctrl_o, 24'h000001);
        check_val("t4_redir", bus5.redirect_o, 0);

        // T5: HALT then an ADDI stream
        drive5(1, 5'b00000, 16'h0200, 0, 0); tick();
        check_val("t5_halt", bus5.halt_o, 1);
        check_val("t5_bundle", bus5.ex_ctrl_o, 24'h000000);
        for (int i = 0; i < 4; i++) begin
            drive5(1, 5'b01000, 16'h0202, 0, 0); tick();
            check_val("t5_valid", bus5.ex_valid_o, 0);
            check_val("t5_sticky", bus5.halt_o, 1);
        end
        async_reset();
        check_val("t5_cleared", bus5.halt_o, 0);

        // T6: six-bit opcode instance, illegal opcode then reset inside SQUASH
        drive5(0, 5'd0, 16'h0, 0, 0);
        bus6.id_valid_i = 1; bus6.id_opc_i = 6'b011011; bus6.id_pc2_i = 16'h0300;
        tick();
        c = bus6.ex_ctrl_o;
        check_val("t6_add_valid", bus6.ex_valid_o, 1);
        check_val("t6_add_op", c[5:0], 6'b011011);
        check_val("t6_add_rw", c[20], 1);
        check_val("t6_add_dest", c[19:18], 2'b01);
        bus6.id_opc_i = 6'b100001; bus6.id_pc2_i = 16'h0302;
        tick();
        check_val("t6_err", bus6.err_o, 1);
        check_val("t6_redir", bus6.redirect_o, 1);
        check_val("t6_rpc", bus6.redirect_pc_o, 16'h0002);
        check_val("t6_epc", bus6.epc_o, 16'h0302);
        check_val("t6_valid", bus6.ex_valid_o, 0);
        bus6.id_valid_i = 0;
        async_reset();

        // Randomized traffic against the model
        halt_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] o;
            o = 5'($urandom_range(31));
            if (o == 5'd0 && $urandom_range(7) != 0) o = 5'b11011;
            drive5($urandom_range(99) < 75, o, 16'($urandom),
                   $urandom_range(99) < 20, $urandom_range(99) < 8);
            tick();
            halt_cnt = m_halt ? halt_cnt + 1 : 0;
            if (halt_cnt > 4 || $urandom_range(99) == 0) begin
                async_reset();
                halt_cnt = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
